ftl_free_fifo_p: RTL and testbench
==================================

Name: ftl_free_fifo_p

Overview:
Parametrised free-block FIFO for the FTL, successor to the fixed 10-bit/1024-entry free list. Single-cycle push/pop strobes replace the legacy edge-detected handshake. Adds true full, occupancy count, almost-empty, and sticky overflow/underflow flags. Adds an optional self-initialising fill that loads block numbers INIT_BASE..INIT_BASE+INIT_COUNT-1 after reset or on request. Storage is the team's dual-port block RAM, instantiated with width DATA_W and address width ADDR_W, with a 1-cycle registered read.

Parameters:
DATA_W, 10, width of each stored block number
ADDR_W, 10, log2 of depth; DEPTH = 2**ADDR_W
INIT_COUNT, 0, number of entries auto-filled after reset/fifo_init; 0 = no fill; legal range 0..DEPTH
INIT_BASE, 0, first value written by the fill; subsequent values increment by 1, modulo 2**DATA_W
AE_LEVEL, 4, fifo_almost_empty asserted when count <= AE_LEVEL

Ports:
clk_50  in  1  system clock
reset_n  in  1  asynchronous active-low reset
fifo_init  in  1  single-cycle pulse: clear FIFO and rerun fill
fifo_data_in  in  DATA_W  push data
fifo_data_wr  in  1  push strobe, one entry per high cycle
fifo_data_rd  in  1  pop strobe, one entry per high cycle
fifo_data_out  out  DATA_W  popped data, qualified by fifo_data_valid
fifo_data_valid  out  1  one-cycle pulse, data on fifo_data_out
fifo_empty  out  1  count == 0
fifo_full  out  1  count == DEPTH
fifo_almost_empty  out  1  count <= AE_LEVEL
fifo_count  out  ADDR_W+1  current occupancy
fifo_busy  out  1  init/fill in progress
fifo_overflow  out  1  sticky: push attempted while full or busy
fifo_underflow  out  1  sticky: pop attempted while empty or busy
fifo_err_clr  in  1  pulse: clear both sticky flags

Behaviour:
- Reset (async, reset_n low) clears the following: wraddr, rdaddr, count, valid, overflow, underflow.
  - State goes to ST_CLEAR. fifo_empty=1, fifo_full=0, fifo_busy=1.
  - fifo_almost_empty=1 (AE_LEVEL >= 0).
- States:
  - ST_CLEAR: zero wraddr, rdaddr, count and the fill counter (1 cycle), then go to ST_FILL if INIT_COUNT>0, else ST_RUN.
  - ST_FILL: write INIT_BASE+i at wraddr, increment wraddr and count. One entry per cycle, INIT_COUNT cycles, then ST_RUN.
  - ST_RUN: normal operation; fifo_busy=0 only here.
  - fifo_init in any state -> ST_CLEAR next cycle. An in-flight fill is abandoned. Sticky flags are kept.
- Push accepted when ST_RUN and wr and !full:
  - RAM write at wraddr; wraddr+1 (wraps at DEPTH); count+1 next cycle.
  - Rejected push: no state change, overflow set.
- Pop accepted when ST_RUN and rd and !empty:
  - RAM read at rdaddr; rdaddr+1 (wraps); count-1 next cycle.
  - fifo_data_valid=1 with the entry on fifo_data_out exactly 1 cycle after the accepted strobe; valid is 0 otherwise.
  - Rejected pop: no valid pulse, underflow set.
- Empty/full are evaluated on the pre-cycle count.
  - Simultaneous push+pop while empty: push accepted, pop rejected (no bypass), underflow set.
  - Simultaneous push+pop while full: pop accepted, push rejected, overflow set.
  - Otherwise simultaneous push+pop: both accepted, count unchanged.
- Any strobe while fifo_busy: rejected, corresponding sticky flag set.
- Back-to-back pops give one valid pulse per cycle, data in FIFO order.
- Sticky flags:
  - fifo_err_clr clears both flags.
  - A new error in the same cycle as fifo_err_clr wins (flag stays 1).
- Outputs fifo_empty/full/almost_empty/count are derived combinationally from the registered count and state.
- Pointers are ADDR_W bits. Count is ADDR_W+1 bits, so full at DEPTH is distinct from empty.
- Fill values wrap modulo 2**DATA_W if INIT_BASE+INIT_COUNT exceeds the data range.

Test Plan:
- ADDR_W=3, INIT_COUNT=0: push 1..8 -> full=1, count=8. 9th push -> overflow=1, count=8. Pop 8x -> valid pulses data 1..8, one cycle after each strobe; empty=1.
- INIT_COUNT=5, INIT_BASE=100: release reset -> busy for 6 cycles, then count=5. Pops return 100,101,102,103,104. almost_empty (AE_LEVEL=4) asserts when count reaches 4.
- Empty FIFO, push 7 and pop in same cycle -> no valid, underflow=1, count=1. Next pop returns 7.
- Wrap: ADDR_W=3, 20 interleaved push/pop of 0..19 -> outputs 0..19 in order, no errors, pointers wrap twice.
- Mid-fill fifo_init (INIT_COUNT=8, asserted at fill cycle 3) -> fill restarts. Final count=8, pops give INIT_BASE..INIT_BASE+7. Push during busy -> overflow=1.
- Async reset low mid-pop stream -> valid=0, count=0 immediately, with no clock edge needed. fifo_err_clr with coincident overflow -> overflow remains 1.

Source files
------------

// File: rtl/ftl_free_fifo_p.sv
// Free-block FIFO for the FTL: push/pop strobes, occupancy flags, sticky error
// flags and an optional self-fill of block numbers after reset or fifo_init.

module ftl_dp_ram #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 10
) (
  input  logic              clk_50,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: storage and read register have no reset so the array maps onto block RAM.
  always_ff @(posedge clk_50) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

module ftl_free_fifo_p #(
  parameter int DATA_W     = 10,
  parameter int ADDR_W     = 10,
  parameter int INIT_COUNT = 0,
  parameter int INIT_BASE  = 0,
  parameter int AE_LEVEL   = 4
) (
  input  logic              clk_50,
  input  logic              reset_n,
  input  logic              fifo_init,
  input  logic [DATA_W-1:0] fifo_data_in,
  input  logic              fifo_data_wr,
  input  logic              fifo_data_rd,
  output logic [DATA_W-1:0] fifo_data_out,
  output logic              fifo_data_valid,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic              fifo_almost_empty,
  output logic [ADDR_W:0]   fifo_count,
  output logic              fifo_busy,
  output logic              fifo_overflow,
  output logic              fifo_underflow,
  input  logic              fifo_err_clr
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [DATA_W-1:0] INIT_BASE_V = DATA_W'(INIT_BASE);

  typedef enum logic [1:0] {ST_CLEAR, ST_FILL, ST_RUN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] wraddr, rdaddr;
  logic [ADDR_W:0]   count, fill_cnt;
  logic              valid;
  logic              run, push_ok, pop_ok, fill_we, fill_last;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata, fill_val;

  assign run       = (state == ST_RUN);
  assign fill_we   = (state == ST_FILL);
  assign push_ok   = run && fifo_data_wr && !fifo_full;
  assign pop_ok    = run && fifo_data_rd && !fifo_empty;
  assign fill_val  = INIT_BASE_V + DATA_W'(fill_cnt);
  assign fill_last = (int'(fill_cnt) == INIT_COUNT - 1);
  assign ram_we    = push_ok || fill_we;
  assign ram_wdata = fill_we ? fill_val : fifo_data_in;

  assign fifo_count        = count;
  assign fifo_empty        = (count == '0);
  assign fifo_full         = (int'(count) == DEPTH);
  assign fifo_almost_empty = (int'(count) <= AE_LEVEL);
  assign fifo_busy         = !run;
  assign fifo_data_valid   = valid;

  ftl_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk_50 (clk_50),
    .we     (ram_we),
    .waddr  (wraddr),
    .wdata  (ram_wdata),
    .re     (pop_ok),
    .raddr  (rdaddr),
    .rdata  (fifo_data_out)
  );

  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_CLEAR;
      wraddr   <= '0;
      rdaddr   <= '0;
      count    <= '0;
      fill_cnt <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= pop_ok;
      if (fifo_init) begin
        state <= ST_CLEAR;
      end else begin
        unique case (state)
          ST_CLEAR: begin
            wraddr   <= '0;
            rdaddr   <= '0;
            count    <= '0;
            fill_cnt <= '0;
            state    <= (INIT_COUNT > 0) ? ST_FILL : ST_RUN;
          end
          ST_FILL: begin
            wraddr   <= wraddr + 1'b1;
            count    <= count + 1'b1;
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_last) state <= ST_RUN;
          end
          ST_RUN: begin
            if (push_ok) wraddr <= wraddr + 1'b1;
            if (pop_ok)  rdaddr <= rdaddr + 1'b1;
            // A simultaneous accepted push and pop leaves the count unchanged.
            count <= count + {{ADDR_W{1'b0}}, push_ok} - {{ADDR_W{1'b0}}, pop_ok};
          end
          default: state <= ST_CLEAR;
        endcase
      end
    end
  end

  // A new error in the same cycle as fifo_err_clr keeps its flag set.
  always_ff @(posedge clk_50 or negedge reset_n) begin
    if (!reset_n) begin
      fifo_overflow  <= 1'b0;
      fifo_underflow <= 1'b0;
    end else begin
      fifo_overflow  <= (fifo_data_wr && !push_ok) || (fifo_overflow  && !fifo_err_clr);
      fifo_underflow <= (fifo_data_rd && !pop_ok)  || (fifo_underflow && !fifo_err_clr);
    end
  end
endmodule

// File: tb/tb_ftl_free_fifo_p.sv
// Directed bench for ftl_free_fifo_p: three instances (no fill, fill of 5 from 100,
// fill of 8 from 1020 wrapping the 10-bit data range), all with depth 8.

module tb_ftl_free_fifo_p;
  logic clk_50 = 1'b0;
  logic reset_n;
  always #10 clk_50 = ~clk_50;

  logic       init [3], wr [3], rd [3], clr [3];
  logic [9:0] din [3], dout [3];
  logic       valid [3], empty [3], full [3], ae [3], busy [3], ovf [3], unf [3];
  logic [3:0] count [3];

  int errors = 0;
  int checks = 0;

  ftl_free_fifo_p #(.DATA_W(10), .ADDR_W(3), .INIT_COUNT(0), .INIT_BASE(0), .AE_LEVEL(4)) dut_a (
    .clk_50(clk_50), .reset_n(reset_n), .fifo_init(init[0]), .fifo_data_in(din[0]),
    .fifo_data_wr(wr[0]), .fifo_data_rd(rd[0]), .fifo_data_out(dout[0]),
    .fifo_data_valid(valid[0]), .fifo_empty(empty[0]), .fifo_full(full[0]),
    .fifo_almost_empty(ae[0]), .fifo_count(count[0]), .fifo_busy(busy[0]),
    .fifo_overflow(ovf[0]), .fifo_underflow(unf[0]), .fifo_err_clr(clr[0]));

  ftl_free_fifo_p #(.DATA_W(10), .ADDR_W(3), .INIT_COUNT(5), .INIT_BASE(100), .AE_LEVEL(4)) dut_b (
    .clk_50(clk_50), .reset_n(reset_n), .fifo_init(init[1]), .fifo_data_in(din[1]),
    .fifo_data_wr(wr[1]), .fifo_data_rd(rd[1]), .fifo_data_out(dout[1]),
    .fifo_data_valid(valid[1]), .fifo_empty(empty[1]), .fifo_full(full[1]),
    .fifo_almost_empty(ae[1]), .fifo_count(count[1]), .fifo_busy(busy[1]),
    .fifo_overflow(ovf[1]), .fifo_underflow(unf[1]), .fifo_err_clr(clr[1]));

  ftl_free_fifo_p #(.DATA_W(10), .ADDR_W(3), .INIT_COUNT(8), .INIT_BASE(1020), .AE_LEVEL(4)) dut_c (
    .clk_50(clk_50), .reset_n(reset_n), .fifo_init(init[2]), .fifo_data_in(din[2]),
    .fifo_data_wr(wr[2]), .fifo_data_rd(rd[2]), .fifo_data_out(dout[2]),
    .fifo_data_valid(valid[2]), .fifo_empty(empty[2]), .fifo_full(full[2]),
    .fifo_almost_empty(ae[2]), .fifo_count(count[2]), .fifo_busy(busy[2]),
    .fifo_overflow(ovf[2]), .fifo_underflow(unf[2]), .fifo_err_clr(clr[2]));

  // Status vector {empty, full, almost_empty, busy, overflow, underflow}.
  function automatic logic [5:0] flags(input int i);
    return {empty[i], full[i], ae[i], busy[i], ovf[i], unf[i]};
  endfunction

  // Drive one cycle from a falling edge; outputs are sampled at the next falling edge.
  task automatic step(input int i, input logic w, input logic r, input logic [9:0] d,
                      input logic c, input logic it);
    wr[i] = w; rd[i] = r; din[i] = d; clr[i] = c; init[i] = it;
    @(negedge clk_50);
    wr[i] = 1'b0; rd[i] = 1'b0; clr[i] = 1'b0; init[i] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (flags(i) !== 6'b101100) begin
        errors++; $display("FAIL reset_flags dut%0d: got %b expected 101100", i, flags(i));
      end
      checks++;
      if (count[i] !== 4'd0 || valid[i] !== 1'b0) begin
        errors++; $display("FAIL reset_count dut%0d: got count=%0d valid=%b expected 0/0", i, count[i], valid[i]);
      end
    end
  endtask

  task automatic test_init_fill();
    for (int n = 1; n <= 5; n++) begin
      step(1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
      checks++;
      if (busy[1] !== 1'b1) begin
        errors++; $display("FAIL fill_busy cycle %0d: got %b expected 1", n, busy[1]);
      end
    end
    checks++;
    if (count[1] !== 4'd4) begin
      errors++; $display("FAIL fill_count_mid: got %0d expected 4", count[1]);
    end
    step(1, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    checks++;
    if (flags(1) !== 6'b000000 || count[1] !== 4'd5) begin
      errors++; $display("FAIL fill_done: got flags=%b count=%0d expected 000000/5", flags(1), count[1]);
    end
    checks++;
    if (busy[0] !== 1'b0 || count[0] !== 4'd0) begin
      errors++; $display("FAIL nofill_run: got busy=%b count=%0d expected 0/0", busy[0], count[0]);
    end
    for (int k = 0; k < 5; k++) begin
      step(1, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0);
      checks++;
      if (valid[1] !== 1'b1 || dout[1] !== 10'(100 + k) || count[1] !== 4'(4 - k) || ae[1] !== 1'b1) begin
        errors++; $display("FAIL fill_pop %0d: got valid=%b data=%0d count=%0d ae=%b expected 1/%0d/%0d/1",
                            k, valid[1], dout[1], count[1], ae[1], 100 + k, 4 - k);
      end
    end
  endtask

  task automatic test_full();
    for (int k = 1; k <= 8; k++) begin
      step(0, 1'b1, 1'b0, 10'(k), 1'b0, 1'b0);
      checks++;
      if (count[0] !== 4'(k)) begin
        errors++; $display("FAIL push_count %0d: got %0d expected %0d", k, count[0], k);
      end
    end
    checks++;
    if (flags(0) !== 6'b010000) begin
      errors++; $display("FAIL full_flags: got %b expected 010000", flags(0));
    end
    step(0, 1'b1, 1'b0, 10'd9, 1'b0, 1'b0);
    checks++;
    if (flags(0) !== 6'b010010 || count[0] !== 4'd8) begin
      errors++; $display("FAIL overflow: got flags=%b count=%0d expected 010010/8", flags(0), count[0]);
    end
    step(0, 1'b1, 1'b0, 10'd10, 1'b1, 1'b0);
    checks++;
    if (ovf[0] !== 1'b1) begin
      errors++; $display("FAIL clr_vs_new_error: got overflow=%b expected 1", ovf[0]);
    end
    step(0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
    checks++;
    if (ovf[0] !== 1'b0) begin
      errors++; $display("FAIL err_clr: got overflow=%b expected 0", ovf[0]);
    end
    step(0, 1'b1, 1'b1, 10'd99, 1'b0, 1'b0);
    checks++;
    if (valid[0] !== 1'b1 || dout[0] !== 10'd1 || count[0] !== 4'd7 || ovf[0] !== 1'b1) begin
      errors++; $display("FAIL full_push_pop: got valid=%b data=%0d count=%0d ovf=%b expected 1/1/7/1",
                          valid[0], dout[0], count[0], ovf[0]);
    end
    step(0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
    for (int k = 2; k <= 8; k++) begin
      step(0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0);
      checks++;
      if (valid[0] !== 1'b1 || dout[0] !== 10'(k) || count[0] !== 4'(8 - k) || ae[0] !== ((8 - k) <= 4)) begin
        errors++; $display("FAIL drain %0d: got valid=%b data=%0d count=%0d ae=%b expected 1/%0d/%0d/%b",
                            k, valid[0], dout[0], count[0], ae[0], k, 8 - k, (8 - k) <= 4);
      end
    end
    step(0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    checks++;
    if (valid[0] !== 1'b0 || flags(0) !== 6'b101000) begin
      errors++; $display("FAIL drained_idle: got valid=%b flags=%b expected 0/101000", valid[0], flags(0));
    end
    step(0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0);
    checks++;
    if (valid[0] !== 1'b0 || flags(0) !== 6'b101001) begin
      errors++; $display("FAIL underflow: got valid=%b flags=%b expected 0/101001", valid[0], flags(0));
    end
    step(0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
  endtask

  task automatic test_push_pop_empty();
    step(0, 1'b1, 1'b1, 10'd7, 1'b0, 1'b0);
    checks++;
    if (valid[0] !== 1'b0 || unf[0] !== 1'b1 || count[0] !== 4'd1) begin
      errors++; $display("FAIL empty_push_pop: got valid=%b unf=%b count=%0d expected 0/1/1", valid[0], unf[0], count[0]);
    end
    step(0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0);
    checks++;
    if (valid[0] !== 1'b1 || dout[0] !== 10'd7 || count[0] !== 4'd0) begin
      errors++; $display("FAIL empty_followup_pop: got valid=%b data=%0d count=%0d expected 1/7/0", valid[0], dout[0], count[0]);
    end
    step(0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    step(0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    for (int k = 1; k < 20; k++) begin
      step(0, 1'b1, 1'b1, 10'(k), 1'b0, 1'b0);
      checks++;
      if (valid[0] !== 1'b1 || dout[0] !== 10'(k - 1) || count[0] !== 4'd1) begin
        errors++; $display("FAIL wrap %0d: got valid=%b data=%0d count=%0d expected 1/%0d/1", k, valid[0], dout[0], count[0], k - 1);
      end
    end
    step(0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0);
    checks++;
    if (valid[0] !== 1'b1 || dout[0] !== 10'd19 || flags(0) !== 6'b101000) begin
      errors++; $display("FAIL wrap_last: got valid=%b data=%0d flags=%b expected 1/19/101000", valid[0], dout[0], flags(0));
    end
  endtask

  task automatic test_mid_fill_init();
    int n;
    checks++;
    if (flags(2) !== 6'b010000 || count[2] !== 4'd8) begin
      errors++; $display("FAIL fill_to_depth: got flags=%b count=%0d expected 010000/8", flags(2), count[2]);
    end
    step(2, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    n = 0;
    while (count[2] !== 4'd3 && n < 20) begin
      step(2, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (n >= 20) begin
      errors++; $display("FAIL refill_start timeout: got count=%0d expected 3 within 20 cycles", count[2]);
    end
    step(2, 1'b1, 1'b0, 10'd5, 1'b0, 1'b0);
    checks++;
    if (busy[2] !== 1'b1 || ovf[2] !== 1'b1) begin
      errors++; $display("FAIL busy_push: got busy=%b ovf=%b expected 1/1", busy[2], ovf[2]);
    end
    step(2, 1'b0, 1'b0, 10'd0, 1'b0, 1'b1);
    n = 0;
    while (busy[2] !== 1'b0 && n < 30) begin
      step(2, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (n !== 9 || count[2] !== 4'd8) begin
      errors++; $display("FAIL refill_done: got cycles=%0d count=%0d expected 9/8", n, count[2]);
    end
    for (int k = 0; k < 8; k++) begin
      step(2, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0);
      checks++;
      if (valid[2] !== 1'b1 || dout[2] !== 10'((1020 + k) % 1024)) begin
        errors++; $display("FAIL refill_pop %0d: got valid=%b data=%0d expected 1/%0d", k, valid[2], dout[2], (1020 + k) % 1024);
      end
    end
    step(2, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
    checks++;
    if (flags(2) !== 6'b101000) begin
      errors++; $display("FAIL refill_end: got flags=%b expected 101000", flags(2));
    end
  endtask

  task automatic test_async_reset();
    for (int k = 1; k <= 3; k++) step(0, 1'b1, 1'b0, 10'(k), 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 10'd0, 1'b0, 1'b0);
    checks++;
    if (valid[0] !== 1'b1 || dout[0] !== 10'd1) begin
      errors++; $display("FAIL pre_reset_pop: got valid=%b data=%0d expected 1/1", valid[0], dout[0]);
    end
    rd[0] = 1'b1;
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if (valid[0] !== 1'b0 || count[0] !== 4'd0 || flags(0) !== 6'b101100) begin
      errors++; $display("FAIL async_reset: got valid=%b count=%0d flags=%b expected 0/0/101100", valid[0], count[0], flags(0));
    end
    rd[0] = 1'b0;
    @(negedge clk_50);
    reset_n = 1'b1;
    step(0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    checks++;
    if (flags(0) !== 6'b101000 || busy[1] !== 1'b1) begin
      errors++; $display("FAIL post_reset: got flags_a=%b busy_b=%b expected 101000/1", flags(0), busy[1]);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      init[i] = 1'b0; wr[i] = 1'b0; rd[i] = 1'b0; clr[i] = 1'b0; din[i] = '0;
    end
    #5;
    test_reset();
    repeat (2) @(negedge clk_50);
    test_reset();
    reset_n = 1'b1;
    test_init_fill();
    test_full();
    test_push_pop_empty();
    test_back_to_back();
    test_mid_fill_init();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
